// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: fixed-latency loads/stores with
// byte strobes, an error flag for bad addresses, and a pipeline stall request.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_mem
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q;
    logic            accept, enter_resp;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            acc_we;
    logic [31:0]     acc_addr, acc_wdata;
    logic [3:0]      acc_wstrb;
    logic            acc_err;
    logic [IdxW-1:0] acc_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = CntW'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = StWait;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the access completes on the acceptance edge, before capture.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
        acc_err = (acc_addr[1:0] != 2'b00) ||
                  ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
        acc_idx = acc_addr[IdxW+1:2];
        rdata_d = (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end

    // Storage is not reset; the rst gate drops a write racing a reset edge.
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= acc_err;
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;
    assign stall_mem  = ((state_q == StIdle) && req_valid) || (state_q == StWait);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=3 transaction table, reset abort,
// and a LATENCY=1 cycle table with back-to-back held requests.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        v3, we3, rdy3, rv3, err3, st3;
    logic [31:0] a3, wd3, rd3;
    logic [3:0]  ws3;

    logic        v1, we1, rdy1, rv1, err1, st1;
    logic [31:0] a1, wd1, rd1;
    logic [3:0]  ws1;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_we(we3), .req_addr(a3), .req_wdata(wd3), .req_wstrb(ws3),
        .req_ready(rdy3), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3),
        .stall_mem(st3)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_we(we1), .req_addr(a1), .req_wdata(wd1), .req_wstrb(ws1),
        .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
        .stall_mem(st1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    typedef struct {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        stall;
    } cyc_t;

    txn_t txns[15];
    cyc_t cycs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full access on the LATENCY=3 instance; request inputs are scrambled during WAIT.
    task automatic run_txn(input int n, input txn_t t);
        string tag;
        tag = $sformatf("txn%0d", n);
        v3 = 1'b1; we3 = t.we; a3 = t.addr; wd3 = t.wdata; ws3 = t.wstrb;
        #1;
        chk({tag, " idle ready"}, 32'(rdy3), 32'd1);
        chk({tag, " idle stall"}, 32'(st3), 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            we3 = ~t.we; a3 = t.addr ^ 32'h4; wd3 = ~t.wdata; ws3 = ~t.wstrb;
            #1;
            chk({tag, " wait ready"}, 32'(rdy3), 32'd0);
            chk({tag, " wait stall"}, 32'(st3), 32'd1);
            chk({tag, " wait resp_valid"}, 32'(rv3), 32'd0);
        end
        @(negedge clk);
        v3 = 1'b0;
        #1;
        chk({tag, " resp_valid"}, 32'(rv3), 32'd1);
        chk({tag, " resp_rdata"}, rd3, t.rdata);
        chk({tag, " resp_err"}, 32'(err3), 32'(t.err));
        chk({tag, " resp stall"}, 32'(st3), 32'd0);
        chk({tag, " resp ready"}, 32'(rdy3), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, " back idle ready"}, 32'(rdy3), 32'd1);
        chk({tag, " back idle resp_valid"}, 32'(rv3), 32'd0);
    endtask

    initial begin
        txns[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        txns[1]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        txns[2]  = '{1'b1, 32'h10,   32'h00000055, 4'b0001, 32'h0,        1'b0};
        txns[3]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hDEADBE55, 1'b0};
        txns[4]  = '{1'b1, 32'h10,   32'hAABBCCDD, 4'b1010, 32'h0,        1'b0};
        txns[5]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hAAADCC55, 1'b0};
        txns[6]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
        txns[7]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hAAADCC55, 1'b0};
        txns[8]  = '{1'b0, 32'h12,   32'h0,        4'b0000, 32'h0,        1'b1};
        txns[9]  = '{1'b1, 32'h0,    32'h11223344, 4'b1111, 32'h0,        1'b0};
        txns[10] = '{1'b1, 32'h1000, 32'h99999999, 4'b1111, 32'h0,        1'b1};
        txns[11] = '{1'b0, 32'h0,    32'h0,        4'b0000, 32'h11223344, 1'b0};
        txns[12] = '{1'b1, 32'hFFC,  32'h0F0F0F0F, 4'b1111, 32'h0,        1'b0};
        txns[13] = '{1'b0, 32'hFFC,  32'h0,        4'b0000, 32'h0F0F0F0F, 1'b0};
        txns[14] = '{1'b1, 32'h20,   32'h600DC0DE, 4'b1111, 32'h0,        1'b0};

        // LATENCY=1, request held across responses: ready toggles every cycle.
        cycs[0]  = '{1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        cycs[1]  = '{1'b1, 1'b1, 32'hC, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
        cycs[2]  = '{1'b1, 1'b1, 32'hC, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        cycs[3]  = '{1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
        cycs[4]  = '{1'b1, 1'b0, 32'h8, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        cycs[5]  = '{1'b1, 1'b0, 32'hC, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0};
        cycs[6]  = '{1'b1, 1'b0, 32'hC, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        cycs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0};
        cycs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        cycs[9]  = '{1'b1, 1'b0, 32'h2, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
        cycs[10] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
        cycs[11] = '{1'b0, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0};

        rst = 1'b1;
        v3 = 1'b0; we3 = 1'b0; a3 = 32'h0; wd3 = 32'h0; ws3 = 4'h0;
        v1 = 1'b0; we1 = 1'b0; a1 = 32'h0; wd1 = 32'h0; ws1 = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ready", 32'(rdy3), 32'd1);
        chk("reset resp_valid", 32'(rv3), 32'd0);
        chk("reset stall", 32'(st3), 32'd0);
        chk("reset resp_err", 32'(err3), 32'd0);
        chk("reset rdata", rd3, 32'h0);
        chk("reset l1 ready", 32'(rdy1), 32'd1);
        chk("reset l1 resp_valid", 32'(rv1), 32'd0);
        @(negedge clk);

        foreach (txns[i]) run_txn(i, txns[i]);

        // Reset during WAIT aborts the store to 0x20.
        v3 = 1'b1; we3 = 1'b1; a3 = 32'h20; wd3 = 32'hCAFEF00D; ws3 = 4'b1111;
        @(negedge clk);
        #1;
        chk("abort in wait stall", 32'(st3), 32'd1);
        v3 = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort async ready", 32'(rdy3), 32'd1);
        chk("abort async stall", 32'(st3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("abort no response", 32'(rv3), 32'd0);
            @(negedge clk);
        end
        run_txn(99, '{1'b0, 32'h20, 32'h0, 4'b0000, 32'h600DC0DE, 1'b0});

        foreach (cycs[i]) begin
            v1 = cycs[i].valid; we1 = cycs[i].we; a1 = cycs[i].addr;
            wd1 = cycs[i].wdata; ws1 = 4'b1111;
            #1;
            chk($sformatf("l1 cyc%0d ready", i), 32'(rdy1), 32'(cycs[i].ready));
            chk($sformatf("l1 cyc%0d resp_valid", i), 32'(rv1), 32'(cycs[i].rv));
            chk($sformatf("l1 cyc%0d stall", i), 32'(st1), 32'(cycs[i].stall));
            if (cycs[i].rv) begin
                chk($sformatf("l1 cyc%0d rdata", i), rd1, cycs[i].rdata);
                chk($sformatf("l1 cyc%0d err", i), 32'(err1), 32'(cycs[i].err));
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipelined core; it answers loads and stores issued from the MEM stage after a fixed latency.
- Replaces the zero-latency data memory when the slower memory model is selected.
- Drives a stall signal that the hazard unit ORs into the stall/flush logic, which freezes the pipeline while an access is outstanding.
- Word-organised storage, byte-strobe writes, error flag on bad addresses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; legal word index range is 0..DEPTH_WORDS-1.
- LATENCY, 3, cycles from request acceptance to the response cycle; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  MEM stage presents an access; held until the response cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7..8i); ignored for loads.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  single-cycle pulse: load data valid / store completed.
- resp_rdata  output  32  load data; meaningful only while resp_valid is 1.
- resp_err  output  1  qualifies resp_valid; the access was misaligned or out of range.
- stall_mem  output  1  freeze request to the hazard unit.

Behaviour:
- Reset is asynchronous and active-high: state returns to IDLE immediately. All outputs are 0 except req_ready, which is 1. The counter and request capture registers are cleared. Memory contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting.
  - RESP: response cycle.
- IDLE -> on a rising edge with req_valid=1:
  - Capture we, addr, wdata and wstrb.
  - Load the counter with LATENCY-1.
  - Go to WAIT if LATENCY>1, else go to RESP.
- IDLE with req_valid=0 stays in IDLE.
- WAIT: req_ready=0. The counter decrements each edge; on the edge where the counter equals 1, go to RESP.
- Net timing: a request accepted at edge k gives a response cycle between edges k+LATENCY and k+LATENCY+1.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0. The next state is always IDLE.
- Throughput: at most one access per LATENCY+1 cycles. A request held continuously with req_valid=1 is re-accepted on the first IDLE edge, with no bubble beyond that.
- Address check on captured addr:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - In either case resp_err=1 and resp_rdata=0 in RESP, and a store does not modify memory.
- Load: resp_rdata = mem[addr[31:2]], read at the edge entering RESP and held registered during RESP.
- Store: at the edge entering RESP, each byte lane with its wstrb bit set is written from wdata; the other lanes are unchanged. resp_rdata=0. wstrb=0000 completes normally with no change to memory.
- stall_mem = (state==IDLE && req_valid) || state==WAIT. stall_mem is 0 in RESP so the pipeline advances in that cycle, carrying the load data.
- Request inputs are sampled only at the acceptance edge. Changes to them in WAIT or RESP are ignored.
- Reset asserted in WAIT or RESP aborts the access: no response is produced, and a pending store is dropped with memory unchanged.
- The counter width is sized for LATENCY.
- LATENCY=1 skips WAIT entirely.

Test Plan:
- Reset values: assert rst for 2 cycles, then release. Required: req_ready=1, resp_valid=0, stall_mem=0, resp_err=0.
- Store then load, LATENCY=3:
  - Store addr=0x10, wdata=0xDEADBEEF, wstrb=1111; stall_mem is high for 3 cycles, then resp_valid pulses with resp_err=0.
  - Then load from 0x10; resp_rdata=0xDEADBEEF exactly 3 cycles after acceptance.
- Byte strobes: after the store above, store addr=0x10, wdata=0x00000055, wstrb=0001, then load 0x10. Required: resp_rdata=0xDEADBE55.
- Errors:
  - Load addr=0x12 -> resp_err=1, resp_rdata=0.
  - Store addr=0x1000 with DEPTH_WORDS=1024 -> resp_err=1; a subsequent load of 0x0 returns its prior value unchanged.
- Reset mid-op: issue a store of 0xCAFEF00D to 0x20 and assert rst during WAIT. Required: no resp_valid is produced; a later load of 0x20 returns the prior value.
- Back-to-back, LATENCY=1: hold req_valid=1 for two consecutive loads. Required: responses arrive in cycles 2 and 4 after the first acceptance, and req_ready alternates 1,0.
